// File: rtl/dcache_pkg.sv
// Shared definitions for the N-way write-back data cache: FSM states,
// access-size codes and the alignment rule.
package dcache_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WRITEBACK = 2'd1,
        S_REFILL    = 2'd2,
        S_FLUSH     = 2'd3
    } dc_state_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    function automatic logic dc_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            default: return off != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dcache_lane.sv
// Byte-lane steering for one cache word: extracts and extends load data,
// merges store data into the addressed bytes.
module dcache_lane
    import dcache_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rword,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [1:0]      i_off,
    input  logic [1:0]      i_size,
    input  logic            i_unsigned,
    output logic [XLEN-1:0] o_ld,
    output logic [XLEN-1:0] o_st
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0]  w_sh;
    logic [15:0]     w_rsh;
    logic [XLEN-1:0] w_mask;

    assign w_sh  = SHW'({i_off, 3'b000});
    assign w_rsh = 16'(i_rword >> w_sh);

    always_comb begin
        w_mask = '1;
        o_ld   = i_rword;
        case (i_size)
            SZ_BYTE: begin
                w_mask = XLEN'(8'hFF);
                o_ld   = i_unsigned ? XLEN'(w_rsh[7:0]) : {{(XLEN-8){w_rsh[7]}}, w_rsh[7:0]};
            end
            SZ_HALF: begin
                w_mask = XLEN'(16'hFFFF);
                o_ld   = i_unsigned ? XLEN'(w_rsh) : {{(XLEN-16){w_rsh[15]}}, w_rsh};
            end
            default: ;
        endcase
    end

    assign o_st = (i_rword & ~(w_mask << w_sh)) | ((i_wdata & w_mask) << w_sh);

endmodule

// File: rtl/dcache_nway.sv
// Set-associative write-back data cache with round-robin replacement,
// combinational hit path, single-line refill/write-back and a full flush walk.
module dcache_nway
    import dcache_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int ADDR_BITS = 20,
    parameter int WAYS      = 2,
    parameter int SETS      = 4,
    parameter int WORDS     = 4,
    localparam int LINE_W   = WORDS * XLEN,
    localparam int OFF      = $clog2(WORDS * 4),
    localparam int LIDX_W   = ADDR_BITS - OFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MEM_ld,
    input  logic              MEM_str,
    input  logic [1:0]        MEM_size,
    input  logic              MEM_unsigned,
    input  logic [XLEN-1:0]   MEM_alu_out,
    input  logic [XLEN-1:0]   MEM_b2,
    input  logic              Dc_flush,
    output logic [XLEN-1:0]   MEM_data_mem,
    output logic              MEM_stall,
    output logic              Dc_misalign,
    output logic              Dc_mem_req,
    output logic [LIDX_W-1:0] Dc_mem_addr,
    input  logic [LINE_W-1:0] MEM_data_line,
    input  logic              MEM_mem_valid,
    output logic              Dc_wb_req,
    output logic [LIDX_W-1:0] Dc_wb_addr,
    output logic [LINE_W-1:0] Dc_wb_wline,
    input  logic              Dc_wb_ack
);

    localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int SB  = (SETS > 1) ? $clog2(SETS) : 1;
    localparam int WOB = (WORDS > 1) ? $clog2(WORDS) : 1;

    // Tags hold the full line index so write-back addresses come straight from the tag array.
    logic              r_valid [SETS][WAYS];
    logic              r_dirty [SETS][WAYS];
    logic [LIDX_W-1:0] r_tag   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];
    logic [WB-1:0]     r_rr    [SETS];

    dc_state_t         r_state;
    logic [LIDX_W-1:0] r_line;
    logic [SB-1:0]     r_set, r_fset;
    logic [WB-1:0]     r_way, r_fway;
    logic              r_mem_req, r_wb_req;
    logic [LIDX_W-1:0] r_wb_addr;
    logic [LINE_W-1:0] r_wb_wline;

    logic [LIDX_W-1:0] w_line;
    logic [SB-1:0]     w_set;
    logic [WOB-1:0]    w_word;
    logic              w_hit, w_inv;
    logic [WB-1:0]     w_hway, w_vway;
    logic              w_acc, w_store, w_load, w_mis, w_idle, w_miss, w_flast;
    logic [XLEN-1:0]   w_rword, w_ld, w_st;
    logic              w_unused_hi;

    assign w_unused_hi = ^MEM_alu_out[XLEN-1:ADDR_BITS];

    assign w_line  = MEM_alu_out[ADDR_BITS-1:OFF];
    assign w_set   = SB'(w_line % LIDX_W'(SETS));
    assign w_word  = WOB'(MEM_alu_out[OFF-1:0] >> 2);
    assign w_acc   = MEM_ld | MEM_str;
    assign w_store = MEM_str;
    assign w_load  = MEM_ld & ~MEM_str;
    assign w_mis   = w_acc & dc_misaligned(MEM_size, MEM_alu_out[1:0]);
    assign w_idle  = (r_state == S_IDLE);
    assign w_miss  = w_idle & w_acc & ~w_mis & ~w_hit;
    assign w_flast = (r_fway == WB'(WAYS - 1)) && (r_fset == SB'(SETS - 1));

    always_comb begin
        w_hit  = 1'b0;
        w_hway = '0;
        w_inv  = 1'b0;
        w_vway = r_rr[w_set];
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!w_hit && r_valid[w_set][WB'(i)] && (r_tag[w_set][WB'(i)] == w_line)) begin
                w_hit  = 1'b1;
                w_hway = WB'(i);
            end
            if (!w_inv && !r_valid[w_set][WB'(i)]) begin
                w_inv  = 1'b1;
                w_vway = WB'(i);
            end
        end
    end

    assign w_rword = r_data[w_set][w_hway][w_word*XLEN +: XLEN];

    dcache_lane #(.XLEN(XLEN)) u_lane (
        .i_rword    (w_rword),
        .i_wdata    (MEM_b2),
        .i_off      (MEM_alu_out[1:0]),
        .i_size     (MEM_size),
        .i_unsigned (MEM_unsigned),
        .o_ld       (w_ld),
        .o_st       (w_st)
    );

    always_comb begin
        if (!w_load)            MEM_data_mem = MEM_alu_out;
        else if (w_mis || !w_hit) MEM_data_mem = '0;
        else                    MEM_data_mem = w_ld;
    end

    assign MEM_stall   = ~rst & (~w_idle | w_miss);
    assign Dc_misalign = ~rst & w_idle & w_mis;
    assign Dc_mem_req  = r_mem_req;
    assign Dc_mem_addr = r_line;
    assign Dc_wb_req   = r_wb_req;
    assign Dc_wb_addr  = r_wb_addr;
    assign Dc_wb_wline = r_wb_wline;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_mem_req  <= 1'b0;
            r_wb_req   <= 1'b0;
            r_wb_addr  <= '0;
            r_wb_wline <= '0;
            for (int unsigned s = 0; s < SETS; s++) begin
                r_rr[SB'(s)] <= '0;
                for (int unsigned w = 0; w < WAYS; w++) begin
                    r_valid[SB'(s)][WB'(w)] <= 1'b0;
                    r_dirty[SB'(s)][WB'(w)] <= 1'b0;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_acc && !w_mis) begin
                        if (w_hit) begin
                            if (w_store) begin
                                r_data[w_set][w_hway][w_word*XLEN +: XLEN] <= w_st;
                                r_dirty[w_set][w_hway] <= 1'b1;
                            end
                        end else begin
                            r_line <= w_line;
                            r_set  <= w_set;
                            r_way  <= w_vway;
                            if (r_valid[w_set][w_vway] && r_dirty[w_set][w_vway]) begin
                                r_wb_req   <= 1'b1;
                                r_wb_addr  <= r_tag[w_set][w_vway];
                                r_wb_wline <= r_data[w_set][w_vway];
                                r_state    <= S_WRITEBACK;
                            end else begin
                                r_mem_req <= 1'b1;
                                r_state   <= S_REFILL;
                            end
                        end
                    end else if (Dc_flush && !w_acc) begin
                        r_fset  <= '0;
                        r_fway  <= '0;
                        r_state <= S_FLUSH;
                    end
                end
                S_WRITEBACK: begin
                    if (Dc_wb_ack) begin
                        r_wb_req              <= 1'b0;
                        r_dirty[r_set][r_way] <= 1'b0;
                        r_mem_req             <= 1'b1;
                        r_state               <= S_REFILL;
                    end
                end
                S_REFILL: begin
                    if (MEM_mem_valid) begin
                        r_data[r_set][r_way]  <= MEM_data_line;
                        r_valid[r_set][r_way] <= 1'b1;
                        r_dirty[r_set][r_way] <= 1'b0;
                        r_tag[r_set][r_way]   <= r_line;
                        r_rr[r_set]           <= (r_rr[r_set] == WB'(WAYS - 1)) ? '0 : r_rr[r_set] + 1'b1;
                        r_mem_req             <= 1'b0;
                        r_state               <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    // A pending handshake blocks the walk; the entry advances only once it is acked or clean.
                    if (r_wb_req) begin
                        if (Dc_wb_ack) begin
                            r_wb_req                <= 1'b0;
                            r_dirty[r_fset][r_fway] <= 1'b0;
                            if (w_flast) r_state <= S_IDLE;
                            else if (r_fway == WB'(WAYS - 1)) begin
                                r_fway <= '0;
                                r_fset <= r_fset + 1'b1;
                            end else r_fway <= r_fway + 1'b1;
                        end
                    end else if (r_valid[r_fset][r_fway] && r_dirty[r_fset][r_fway]) begin
                        r_wb_req   <= 1'b1;
                        r_wb_addr  <= r_tag[r_fset][r_fway];
                        r_wb_wline <= r_data[r_fset][r_fway];
                    end else if (w_flast) r_state <= S_IDLE;
                    else if (r_fway == WB'(WAYS - 1)) begin
                        r_fway <= '0;
                        r_fset <= r_fset + 1'b1;
                    end else r_fway <= r_fway + 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_nway.sv
// Directed plus randomized check of dcache_nway against a flat byte-memory
// view, a backing line store and a set/way occupancy model.
module tb_dcache_nway;

    localparam int XLEN = 32, AB = 20, WAYS = 2, SETS = 4, WORDS = 4;
    localparam int LW = WORDS * XLEN, LIW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            MEM_ld, MEM_str, MEM_unsigned, Dc_flush, MEM_mem_valid, Dc_wb_ack;
    logic [1:0]      MEM_size;
    logic [XLEN-1:0] MEM_alu_out, MEM_b2, MEM_data_mem;
    logic            MEM_stall, Dc_misalign, Dc_mem_req, Dc_wb_req;
    logic [LIW-1:0]  Dc_mem_addr, Dc_wb_addr;
    logic [LW-1:0]   MEM_data_line, Dc_wb_wline;

    always #5 clk = ~clk;

    dcache_nway #(.XLEN(XLEN), .ADDR_BITS(AB), .WAYS(WAYS), .SETS(SETS), .WORDS(WORDS)) dut (
        .clk(clk), .rst(rst), .MEM_ld(MEM_ld), .MEM_str(MEM_str), .MEM_size(MEM_size),
        .MEM_unsigned(MEM_unsigned), .MEM_alu_out(MEM_alu_out), .MEM_b2(MEM_b2),
        .Dc_flush(Dc_flush), .MEM_data_mem(MEM_data_mem), .MEM_stall(MEM_stall),
        .Dc_misalign(Dc_misalign), .Dc_mem_req(Dc_mem_req), .Dc_mem_addr(Dc_mem_addr),
        .MEM_data_line(MEM_data_line), .MEM_mem_valid(MEM_mem_valid), .Dc_wb_req(Dc_wb_req),
        .Dc_wb_addr(Dc_wb_addr), .Dc_wb_wline(Dc_wb_wline), .Dc_wb_ack(Dc_wb_ack)
    );

    int total = 0, bad = 0;

    logic [7:0]    arch [int];   // bytes stored since the last reset
    logic [LW-1:0] back [int];   // backing memory lines that were written back
    logic [LW-1:0] preset;
    bit            m_valid [SETS][WAYS];
    bit            m_dirty [SETS][WAYS];
    int            m_line  [SETS][WAYS];
    int            m_rr    [SETS];

    function automatic logic [LW-1:0] mem_line(int idx);
        logic [LW-1:0] l;
        if (back.exists(idx)) return back[idx];
        for (int b = 0; b < 16; b++)
            l[b*8 +: 8] = (idx == 16) ? preset[b*8 +: 8] : 8'((idx * 16 + b) * 37 + 11);
        return l;
    endfunction

    function automatic logic [7:0] rd_byte(int a);
        logic [LW-1:0] l;
        if (arch.exists(a)) return arch[a];
        l = mem_line(a / 16);
        return l[(a % 16) * 8 +: 8];
    endfunction

    function automatic logic [LW-1:0] arch_line(int idx);
        logic [LW-1:0] l;
        for (int b = 0; b < 16; b++) l[b*8 +: 8] = rd_byte(idx * 16 + b);
        return l;
    endfunction

    function automatic int m_find(int line);
        for (int w = 0; w < WAYS; w++)
            if (m_valid[line % SETS][w] && m_line[line % SETS][w] == line) return w;
        return -1;
    endfunction

    task automatic model_reset();
        arch.delete();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) begin
                m_valid[s][w] = 0;
                m_dirty[s][w] = 0;
            end
        end
    endtask

    task automatic chk(string tag, logic [LW-1:0] obs, logic [LW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        MEM_ld = 0; MEM_str = 0; MEM_size = 0; MEM_unsigned = 0;
        MEM_alu_out = 0; MEM_b2 = 0;
    endtask

    // One CPU access, entered and left at posedge+1; services any miss traffic.
    task automatic access(bit ld, bit st, logic [1:0] sz, bit uns, int addr,
                          logic [31:0] wd, int wb_lat, int rf_lat);
        int line, set, way, vic, wb_line, stalls, whold, rcnt, wbs, cyc;
        bit mis, exp_wb;
        logic [31:0] exp_ld;
        line = addr / 16; set = line % SETS;
        mis = (sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0);
        way = m_find(line);
        exp_wb = 0; vic = 0; wb_line = 0;
        if (!mis && way < 0) begin
            vic = -1;
            for (int w = 0; w < WAYS; w++) if (vic < 0 && !m_valid[set][w]) vic = w;
            if (vic < 0) vic = m_rr[set];
            exp_wb  = m_valid[set][vic] && m_dirty[set][vic];
            wb_line = m_line[set][vic];
        end
        MEM_ld = ld; MEM_str = st; MEM_size = sz; MEM_unsigned = uns;
        MEM_alu_out = addr; MEM_b2 = wd;
        @(negedge clk);
        chk("misalign", Dc_misalign, mis);
        chk("stall_issue", MEM_stall, !mis && way < 0);
        if (MEM_stall) begin
            stalls = 0; whold = 0; rcnt = 0; wbs = 0; cyc = 0;
            while (MEM_stall && cyc < 100) begin
                cyc++; stalls++;
                chk("req_overlap", Dc_wb_req & Dc_mem_req, 0);
                if (Dc_wb_req) begin
                    whold++;
                    chk("wb_addr", Dc_wb_addr, wb_line);
                    if (whold == wb_lat) begin
                        chk("wb_data", Dc_wb_wline, arch_line(wb_line));
                        back[wb_line] = Dc_wb_wline;
                        Dc_wb_ack = 1; wbs++;
                    end
                end
                if (Dc_mem_req) begin
                    rcnt++;
                    if (rcnt == 1) chk("rf_after_wb", wbs, exp_wb);
                    chk("rf_addr", Dc_mem_addr, line);
                    if (rcnt == rf_lat) begin
                        MEM_data_line = mem_line(line);
                        MEM_mem_valid = 1;
                    end
                end
                tick();
                Dc_wb_ack = 0; MEM_mem_valid = 0;
                MEM_data_line = {$urandom, $urandom, $urandom, $urandom};
                @(negedge clk);
            end
            chk("stall_len", stalls, 1 + (exp_wb ? wb_lat : 0) + rf_lat);
            chk("wb_count", wbs, exp_wb);
            m_valid[set][vic] = 1; m_dirty[set][vic] = 0; m_line[set][vic] = line;
            m_rr[set] = (m_rr[set] + 1) % WAYS;
            way = vic;
        end
        if (ld && !st) begin
            if (mis) exp_ld = 0;
            else if (sz == 2'd0) exp_ld = uns ? {24'd0, rd_byte(addr)} : {{24{rd_byte(addr)[7]}}, rd_byte(addr)};
            else if (sz == 2'd1) exp_ld = uns ? {16'd0, rd_byte(addr+1), rd_byte(addr)}
                                             : {{16{rd_byte(addr+1)[7]}}, rd_byte(addr+1), rd_byte(addr)};
            else exp_ld = {rd_byte(addr+3), rd_byte(addr+2), rd_byte(addr+1), rd_byte(addr)};
        end else exp_ld = addr;
        chk("load_data", MEM_data_mem, exp_ld);
        tick();
        if (st && !mis) begin
            for (int b = 0; b < (1 << sz); b++) arch[addr + b] = wd[b*8 +: 8];
            m_dirty[set][way] = 1;
        end
        idle_inputs();
    endtask

    task automatic flush(int wb_lat);
        int q[$];
        int k, whold, cyc;
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++)
                if (m_valid[s][w] && m_dirty[s][w]) q.push_back(m_line[s][w]);
        Dc_flush = 1;
        tick();
        Dc_flush = 0;
        @(negedge clk);
        k = 0; whold = 0; cyc = 0;
        while (MEM_stall && cyc < 200) begin
            cyc++;
            chk("flush_no_rf", Dc_mem_req, 0);
            if (Dc_wb_req) begin
                whold++;
                chk("flush_addr", Dc_wb_addr, (k < q.size()) ? q[k] : -1);
                if (whold == wb_lat && k < q.size()) begin
                    chk("flush_data", Dc_wb_wline, arch_line(q[k]));
                    back[q[k]] = Dc_wb_wline;
                    Dc_wb_ack = 1; k++; whold = 0;
                end
            end
            tick();
            Dc_wb_ack = 0;
            @(negedge clk);
        end
        chk("flush_count", k, q.size());
        for (int s = 0; s < SETS; s++)
            for (int w = 0; w < WAYS; w++) m_dirty[s][w] = 0;
        tick();
    endtask

    initial begin
        int line, off, kind;
        logic [1:0] sz;
        preset = 128'hDDCCBBAA_CCBBAA99_88776655_44332211;
        rst = 1; Dc_flush = 0; MEM_mem_valid = 0; Dc_wb_ack = 0; MEM_data_line = '0;
        idle_inputs();
        model_reset();
        tick(); tick();
        @(negedge clk);
        chk("rst_mem_req", Dc_mem_req, 0);
        chk("rst_wb_req", Dc_wb_req, 0);
        chk("rst_stall", MEM_stall, 0);
        chk("rst_misalign", Dc_misalign, 0);
        chk("rst_wb_addr", Dc_wb_addr, 0);
        chk("rst_wb_wline", Dc_wb_wline, 0);
        tick();
        rst = 0;

        // cold word load of the preset line, then byte stores and sign extension
        access(1, 0, 2'd2, 0, 'h100, 0, 5, 3);
        access(0, 1, 2'd0, 0, 'h101, 32'h5A, 5, 3);
        access(1, 0, 2'd0, 0, 'h101, 0, 5, 3);
        access(0, 1, 2'd0, 0, 'h102, 32'h80, 5, 3);
        access(1, 0, 2'd0, 0, 'h102, 0, 5, 3);
        access(1, 0, 2'd0, 1, 'h102, 0, 5, 3);
        access(1, 0, 2'd1, 0, 'h102, 0, 5, 3);
        // misaligned accesses leave everything untouched
        access(1, 0, 2'd1, 0, 'h103, 0, 5, 3);
        access(1, 1, 2'd2, 0, 'h102, 32'hDEADBEEF, 5, 3);
        access(1, 0, 2'd2, 0, 'h100, 0, 5, 3);
        // both ways of set 0 dirty, then a third tag evicts way 0
        access(0, 1, 2'd2, 0, 'h140, 32'h12345678, 2, 2);
        access(1, 0, 2'd2, 0, 'h180, 0, 5, 3);
        access(1, 0, 2'd2, 0, 'h100, 0, 2, 1);
        // flush request coincident with an access is ignored
        Dc_flush = 1;
        access(1, 0, 2'd2, 0, 'h100, 0, 2, 1);
        Dc_flush = 0;
        @(negedge clk);
        chk("flush_ignored", MEM_stall, 0);
        tick();
        // stray handshakes in IDLE
        MEM_mem_valid = 1; Dc_wb_ack = 1; MEM_data_line = '1;
        tick();
        MEM_mem_valid = 0; Dc_wb_ack = 0;
        access(1, 0, 2'd2, 0, 'h104, 0, 2, 1);
        // three dirty lines flushed in set/way order, second flush finds none
        access(0, 1, 2'd1, 0, 'h112, 32'hBEEF, 1, 2);
        access(0, 1, 2'd0, 0, 'h127, 32'h33, 1, 2);
        access(0, 1, 2'd2, 0, 'h184, 32'hCAFE0001, 1, 2);
        flush(3);
        flush(2);
        // reset in the second REFILL cycle abandons the transaction
        MEM_ld = 1; MEM_size = 2'd2; MEM_alu_out = 'h300;
        @(negedge clk);
        chk("rst033_stall", MEM_stall, 1);
        tick();
        @(negedge clk);
        chk("rst033_req", Dc_mem_req, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        chk("rst033_req_drop", Dc_mem_req, 0);
        chk("rst033_stall_drop", MEM_stall, 0);
        tick();
        MEM_mem_valid = 1; MEM_data_line = '1;
        tick();
        MEM_mem_valid = 0;
        access(1, 0, 2'd2, 0, 'h300, 0, 2, 2);
        access(1, 0, 2'd2, 0, 'h100, 0, 2, 2);

        for (int n = 0; n < 80; n++) begin
            line = 16 + $urandom_range(0, 15);
            sz   = 2'($urandom_range(0, 2));
            off  = $urandom_range(0, 15);
            if ($urandom_range(0, 7) != 0) off = off & ~((1 << sz) - 1);
            kind = $urandom_range(0, 2);
            access(kind != 1, kind != 0, sz, 1'($urandom_range(0, 1)), line * 16 + off,
                   $urandom, $urandom_range(1, 4), $urandom_range(1, 4));
            if ($urandom_range(0, 15) == 0) flush($urandom_range(1, 3));
        end
        flush(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
